// File: rtl/canny_frame_ctrl_if.sv
// Host configuration channel for canny_frame_ctrl: valid/ready request carrying
// thresholds, mode and enable, plus a one-cycle reject pulse back to the host.
interface canny_frame_ctrl_if #(
    parameter int TH_WIDTH = 8
) ();
    logic                cfg_valid;
    logic                cfg_ready;
    logic [TH_WIDTH-1:0] cfg_low_th;
    logic [TH_WIDTH-1:0] cfg_high_th;
    logic [1:0]          cfg_mode;
    logic                cfg_enable;
    logic                cfg_err;

    // Transfer when cfg_valid & cfg_ready at a rising clk edge; payload must be
    // stable while cfg_valid is high; cfg_ready never depends on cfg_valid.
    modport master (
        output cfg_valid, cfg_low_th, cfg_high_th, cfg_mode, cfg_enable,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_low_th, cfg_high_th, cfg_mode, cfg_enable,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/canny_frame_ctrl.sv
// Frame-synchronous control for the Canny pipeline: buffers one host config,
// commits it at a vsync rise, gates the pipeline and checks frame geometry.
module canny_frame_ctrl #(
    parameter int DATA_DEPTH  = 1920,
    parameter int IMG_HEIGHT  = 1080,
    parameter int TH_WIDTH    = 8,
    parameter int DEF_LOW_TH  = 50,
    parameter int DEF_HIGH_TH = 100
) (
    input  logic                clk,
    input  logic                rst_s,
    canny_frame_ctrl_if.slave   cfg,
    input  logic                per_frame_vsync,
    input  logic                per_frame_href,
    input  logic                per_frame_clken,
    output logic [TH_WIDTH-1:0] active_low_th,
    output logic [TH_WIDTH-1:0] active_high_th,
    output logic [1:0]          active_mode,
    output logic                pipe_enable,
    output logic                frame_done,
    output logic                size_err,
    output logic [15:0]         frame_cnt,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_e;

    localparam logic [11:0]         DEPTH_L  = 12'(DATA_DEPTH);
    localparam logic [11:0]         HEIGHT_L = 12'(IMG_HEIGHT);
    localparam logic [11:0]         CNT_MAX  = 12'hFFF;
    localparam logic [TH_WIDTH-1:0] DEF_LOW  = TH_WIDTH'(DEF_LOW_TH);
    localparam logic [TH_WIDTH-1:0] DEF_HIGH = TH_WIDTH'(DEF_HIGH_TH);

    state_e              state_q, state_d;
    logic                vs_d_q, href_d_q;
    logic                pend_q, pend_d;
    logic [TH_WIDTH-1:0] pend_low_q, pend_low_d;
    logic [TH_WIDTH-1:0] pend_high_q, pend_high_d;
    logic [1:0]          pend_mode_q, pend_mode_d;
    logic                pend_en_q, pend_en_d;
    logic [TH_WIDTH-1:0] active_low_th_q, active_low_th_d;
    logic [TH_WIDTH-1:0] active_high_th_q, active_high_th_d;
    logic [1:0]          active_mode_q, active_mode_d;
    logic                active_en_q, active_en_d;
    logic                pipe_enable_q, pipe_enable_d;
    logic                frame_done_q, frame_done_d;
    logic                size_err_q, size_err_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                cfg_err_q, cfg_err_d;
    logic [11:0]         pix_cnt_q, pix_cnt_d;
    logic [11:0]         line_cnt_q, line_cnt_d;
    logic                line_err_q, line_err_d;

    logic        boundary;
    logic        href_fall;
    logic        xfer;
    logic        cfg_bad;
    logic        commit;
    logic        eff_en;
    logic        line_err_eff;
    logic [11:0] line_cnt_eff;

    assign boundary  = per_frame_vsync & ~vs_d_q;
    assign href_fall = ~per_frame_href & href_d_q;
    assign xfer      = cfg.cfg_valid & ~pend_q;
    assign cfg_bad   = cfg.cfg_low_th > cfg.cfg_high_th;
    assign commit    = boundary & pend_q;
    // Enable that holds after this boundary: the committed one if a commit happens now.
    assign eff_en    = commit ? pend_en_q : active_en_q;

    // A line that ends on the boundary cycle still belongs to the frame being closed.
    assign line_err_eff = line_err_q | (href_fall & (pix_cnt_q != DEPTH_L));
    assign line_cnt_eff = (href_fall && line_cnt_q != CNT_MAX) ? line_cnt_q + 12'd1
                                                               : line_cnt_q;

    always_comb begin
        state_d          = state_q;
        pend_d           = pend_q;
        pend_low_d       = pend_low_q;
        pend_high_d      = pend_high_q;
        pend_mode_d      = pend_mode_q;
        pend_en_d        = pend_en_q;
        active_low_th_d  = active_low_th_q;
        active_high_th_d = active_high_th_q;
        active_mode_d    = active_mode_q;
        active_en_d      = active_en_q;
        frame_cnt_d      = frame_cnt_q;
        frame_done_d     = 1'b0;
        size_err_d       = 1'b0;
        cfg_err_d        = 1'b0;
        pix_cnt_d        = pix_cnt_q;
        line_cnt_d       = line_cnt_q;
        line_err_d       = line_err_q;

        if (commit) begin
            active_low_th_d  = pend_low_q;
            active_high_th_d = pend_high_q;
            active_mode_d    = pend_mode_q;
            active_en_d      = pend_en_q;
            pend_d           = 1'b0;
        end

        // Only reachable with pend_q=0, so never collides with the commit above.
        if (xfer) begin
            if (cfg_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_low_d  = cfg.cfg_low_th;
                pend_high_d = cfg.cfg_high_th;
                pend_mode_d = (cfg.cfg_mode == 2'd3) ? 2'd0 : cfg.cfg_mode;
                pend_en_d   = cfg.cfg_enable;
            end
        end

        if (state_q == ST_ACTIVE) begin
            if (href_fall) begin
                pix_cnt_d  = 12'd0;
                line_cnt_d = line_cnt_eff;
                line_err_d = line_err_eff;
            end else if (per_frame_clken && per_frame_href && pix_cnt_q != CNT_MAX) begin
                pix_cnt_d = pix_cnt_q + 12'd1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (commit && pend_en_q) state_d = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                if (boundary) state_d = eff_en ? ST_ACTIVE : ST_IDLE;
            end
            ST_ACTIVE: begin
                if (boundary) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    size_err_d   = line_err_eff | (line_cnt_eff != HEIGHT_L);
                    if (!eff_en) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Geometry counters only run inside an active frame.
        if (boundary || state_q != ST_ACTIVE) begin
            pix_cnt_d  = 12'd0;
            line_cnt_d = 12'd0;
            line_err_d = 1'b0;
        end

        pipe_enable_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst_s) begin
            state_q          <= ST_IDLE;
            vs_d_q           <= 1'b0;
            href_d_q         <= 1'b0;
            pend_q           <= 1'b0;
            pend_low_q       <= '0;
            pend_high_q      <= '0;
            pend_mode_q      <= 2'd0;
            pend_en_q        <= 1'b0;
            active_low_th_q  <= DEF_LOW;
            active_high_th_q <= DEF_HIGH;
            active_mode_q    <= 2'd0;
            active_en_q      <= 1'b0;
            pipe_enable_q    <= 1'b0;
            frame_done_q     <= 1'b0;
            size_err_q       <= 1'b0;
            frame_cnt_q      <= 16'd0;
            cfg_err_q        <= 1'b0;
            pix_cnt_q        <= 12'd0;
            line_cnt_q       <= 12'd0;
            line_err_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            vs_d_q           <= per_frame_vsync;
            href_d_q         <= per_frame_href;
            pend_q           <= pend_d;
            pend_low_q       <= pend_low_d;
            pend_high_q      <= pend_high_d;
            pend_mode_q      <= pend_mode_d;
            pend_en_q        <= pend_en_d;
            active_low_th_q  <= active_low_th_d;
            active_high_th_q <= active_high_th_d;
            active_mode_q    <= active_mode_d;
            active_en_q      <= active_en_d;
            pipe_enable_q    <= pipe_enable_d;
            frame_done_q     <= frame_done_d;
            size_err_q       <= size_err_d;
            frame_cnt_q      <= frame_cnt_d;
            cfg_err_q        <= cfg_err_d;
            pix_cnt_q        <= pix_cnt_d;
            line_cnt_q       <= line_cnt_d;
            line_err_q       <= line_err_d;
        end
    end

    assign cfg.cfg_ready   = ~pend_q;
    assign cfg.cfg_err     = cfg_err_q;
    assign active_low_th   = active_low_th_q;
    assign active_high_th  = active_high_th_q;
    assign active_mode     = active_mode_q;
    assign pipe_enable     = pipe_enable_q;
    assign frame_done      = frame_done_q;
    assign size_err        = size_err_q;
    assign frame_cnt       = frame_cnt_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Directed bench for canny_frame_ctrl using a reduced 8x4 frame geometry so
// whole frames stay short; expected values are hand-derived per step.
module tb_canny_frame_ctrl;
    localparam int TH_W   = 8;
    localparam int DEPTH  = 8;
    localparam int HEIGHT = 4;
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACTIVE = 2'd2;

    // clock / reset
    logic clk = 1'b0;
    logic rst_s = 1'b1;
    always #5 clk = ~clk;

    logic            vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [TH_W-1:0] active_low_th, active_high_th;
    logic [1:0]      active_mode, state_dbg;
    logic            pipe_enable, frame_done, size_err;
    logic [15:0]     frame_cnt;

    canny_frame_ctrl_if #(.TH_WIDTH(TH_W)) cfg_bus ();

    canny_frame_ctrl #(
        .DATA_DEPTH(DEPTH), .IMG_HEIGHT(HEIGHT), .TH_WIDTH(TH_W),
        .DEF_LOW_TH(50), .DEF_HIGH_TH(100)
    ) dut (
        .clk(clk), .rst_s(rst_s), .cfg(cfg_bus),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .active_low_th(active_low_th), .active_high_th(active_high_th),
        .active_mode(active_mode), .pipe_enable(pipe_enable),
        .frame_done(frame_done), .size_err(size_err),
        .frame_cnt(frame_cnt), .state_dbg(state_dbg)
    );

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // driver tasks
    task automatic send_line(input int npix, input bit fall);
        @(negedge clk); href = 1'b1; clken = 1'b0;
        repeat (npix) begin @(negedge clk); clken = 1'b1; end
        if (fall) begin
            @(negedge clk); href = 1'b0; clken = 1'b0;
            @(negedge clk); clken = 1'b1;
        end
    endtask

    task automatic send_frame(input int nlines, input int short_idx);
        for (int l = 0; l < nlines; l++) send_line((l == short_idx) ? DEPTH - 1 : DEPTH, 1'b1);
    endtask

    task automatic vs_begin();
        @(negedge clk); href = 1'b0; clken = 1'b0; vsync = 1'b1;
        @(negedge clk);
    endtask

    task automatic vs_end();
        vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic frame_end_check(input string tag, input logic exp_pipe, input logic [15:0] exp_cnt);
        logic [0:0] exp_sz;
        vs_begin();
        exp_sz = exp_q.pop_front();
        check({tag, "_done"}, frame_done, 1);
        check({tag, "_size_err"}, size_err, exp_sz);
        check({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
        check({tag, "_pipe"}, pipe_enable, exp_pipe);
    endtask

    task automatic vs_drop(input string tag);
        vs_end();
        check({tag, "_done_drop"}, frame_done, 0);
        check({tag, "_size_drop"}, size_err, 0);
    endtask

    task automatic cfg_write(input logic [7:0] lo, input logic [7:0] hi, input logic [1:0] mode,
                             input logic en, input bit exp_err);
        @(negedge clk);
        check("cfg_ready_pre", cfg_bus.cfg_ready, 1);
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_low_th = lo; cfg_bus.cfg_high_th = hi;
        cfg_bus.cfg_mode = mode; cfg_bus.cfg_enable = en;
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        check("cfg_err_pulse", cfg_bus.cfg_err, exp_err);
        check("cfg_ready_post", cfg_bus.cfg_ready, exp_err);
        @(negedge clk);
        check("cfg_err_clear", cfg_bus.cfg_err, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_low"}, active_low_th, 50);
        check({tag, "_high"}, active_high_th, 100);
        check({tag, "_mode"}, active_mode, 0);
        check({tag, "_ready"}, cfg_bus.cfg_ready, 1);
        check({tag, "_cfg_err"}, cfg_bus.cfg_err, 0);
        check({tag, "_pipe"}, pipe_enable, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_size"}, size_err, 0);
        check({tag, "_cnt"}, frame_cnt, 0);
        check({tag, "_state"}, state_dbg, S_IDLE);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_low_th = '0; cfg_bus.cfg_high_th = '0;
        cfg_bus.cfg_mode = 2'd0; cfg_bus.cfg_enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");

        for (int i = 0; i < 10; i++) begin
            vs_begin();
            check("idle_no_done", frame_done, 0);
            vs_end();
        end
        check("idle_cnt", frame_cnt, 0);
        check("idle_pipe", pipe_enable, 0);

        // enable: first boundary commits, second enters ACTIVE
        cfg_write(8'd30, 8'd90, 2'd0, 1'b1, 1'b0);
        send_frame(HEIGHT, -1);
        vs_begin();
        check("c1_low", active_low_th, 30);
        check("c1_high", active_high_th, 90);
        check("c1_pipe", pipe_enable, 0);
        check("c1_state", state_dbg, S_WAIT);
        check("c1_ready", cfg_bus.cfg_ready, 1);
        vs_end();
        send_frame(HEIGHT, -1);
        check("pre_act_pipe", pipe_enable, 0);
        vs_begin();
        check("act_pipe", pipe_enable, 1);
        check("act_state", state_dbg, S_ACTIVE);
        check("act_no_done", frame_done, 0);
        check("act_cnt", frame_cnt, 0);
        vs_end();
        exp_q.push_back(1'b0); send_frame(HEIGHT, -1); frame_end_check("f1", 1'b1, 16'd1); vs_drop("f1");
        exp_q.push_back(1'b0); send_frame(HEIGHT, -1); frame_end_check("f2", 1'b1, 16'd2); vs_drop("f2");

        // mid-frame write waits for the boundary
        exp_q.push_back(1'b0);
        send_frame(2, -1);
        cfg_write(8'd40, 8'd120, 2'd0, 1'b1, 1'b0);
        send_frame(2, -1);
        check("mid_low_hold", active_low_th, 30);
        check("mid_high_hold", active_high_th, 90);
        check("mid_ready_low", cfg_bus.cfg_ready, 0);
        frame_end_check("f3", 1'b1, 16'd3);
        check("f3_low", active_low_th, 40);
        check("f3_high", active_high_th, 120);
        check("f3_ready", cfg_bus.cfg_ready, 1);
        vs_drop("f3");

        // rejected config
        cfg_write(8'd100, 8'd50, 2'd0, 1'b1, 1'b1);
        exp_q.push_back(1'b0); send_frame(HEIGHT, -1); frame_end_check("f4", 1'b1, 16'd4);
        check("rej_low", active_low_th, 40);
        check("rej_high", active_high_th, 120);
        vs_drop("f4");

        // equal thresholds legal, mode 2
        cfg_write(8'd60, 8'd60, 2'd2, 1'b1, 1'b0);
        exp_q.push_back(1'b0); send_frame(HEIGHT, -1); frame_end_check("f5", 1'b1, 16'd5);
        check("eq_low", active_low_th, 60);
        check("eq_high", active_high_th, 60);
        check("eq_mode", active_mode, 2);
        vs_drop("f5");

        // reserved mode maps to 0
        cfg_write(8'd10, 8'd20, 2'd3, 1'b1, 1'b0);
        exp_q.push_back(1'b0); send_frame(HEIGHT, -1); frame_end_check("f6", 1'b1, 16'd6);
        check("m3_mode", active_mode, 0);
        check("m3_low", active_low_th, 10);
        vs_drop("f6");

        // geometry errors, then a clean frame
        exp_q.push_back(1'b1); send_frame(HEIGHT, 1);      frame_end_check("short_line", 1'b1, 16'd7); vs_drop("short_line");
        exp_q.push_back(1'b1); send_frame(HEIGHT - 1, -1); frame_end_check("short_frame", 1'b1, 16'd8); vs_drop("short_frame");
        exp_q.push_back(1'b0); send_frame(HEIGHT, -1);     frame_end_check("clean", 1'b1, 16'd9); vs_drop("clean");

        // last href fall lands on the boundary cycle
        exp_q.push_back(1'b0);
        send_frame(HEIGHT - 1, -1);
        send_line(DEPTH, 1'b0);
        frame_end_check("fall_on_vs", 1'b1, 16'd10);
        vs_drop("fall_on_vs");

        // disable at frame end
        cfg_write(8'd10, 8'd20, 2'd0, 1'b0, 1'b0);
        exp_q.push_back(1'b0);
        send_frame(HEIGHT, -1);
        check("dis_pipe_hold", pipe_enable, 1);
        frame_end_check("dis", 1'b0, 16'd11);
        check("dis_state", state_dbg, S_IDLE);
        vs_drop("dis");
        send_frame(HEIGHT, -1);
        vs_begin();
        check("idle2_done", frame_done, 0);
        check("idle2_cnt", frame_cnt, 11);
        vs_end();

        // transfer on the boundary cycle commits only at the next boundary
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_low_th = 8'd20; cfg_bus.cfg_high_th = 8'd40;
        cfg_bus.cfg_mode = 2'd1; cfg_bus.cfg_enable = 1'b1;
        vsync = 1'b1;
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        check("sim_low_hold", active_low_th, 10);
        check("sim_ready", cfg_bus.cfg_ready, 0);
        check("sim_state", state_dbg, S_IDLE);
        vs_end();
        vs_begin();
        check("sim_low", active_low_th, 20);
        check("sim_high", active_high_th, 40);
        check("sim_mode", active_mode, 1);
        check("sim_wait", state_dbg, S_WAIT);
        vs_end();

        // reset mid-frame with a pending config
        cfg_write(8'd70, 8'd80, 2'd1, 1'b1, 1'b0);
        send_frame(2, -1);
        @(negedge clk); rst_s = 1'b1;
        @(negedge clk); rst_s = 1'b0;
        check_reset_vals("mid_rst");
        send_frame(HEIGHT, -1);
        vs_begin();
        check("post_rst_low", active_low_th, 50);
        check("post_rst_state", state_dbg, S_IDLE);
        check("post_rst_ready", cfg_bus.cfg_ready, 1);
        vs_end();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
